// File: rtl/multu_hilo_pkg.sv
// Shared definitions for the MULTU/HI/LO unit: the control codes coming from
// the ALU control stage and the sequencer state encoding.
package multu_hilo_pkg;

  localparam logic [5:0] SIG_MULTU   = 6'b011001;
  localparam logic [5:0] SIG_HILO_WR = 6'b111111;
  localparam logic [5:0] SIG_MFHI    = 6'b010000;
  localparam logic [5:0] SIG_MFLO    = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Decides the value the read port should present for a given control code.
  function automatic logic [1:0] read_sel(input logic [5:0] sig);
    logic [1:0] sel;
    sel = 2'b00;
    if (sig == SIG_MFHI) sel = 2'b01;
    else if (sig == SIG_MFLO) sel = 2'b10;
    return sel;
  endfunction

endpackage

// File: rtl/multu_hilo_mult_step.sv
// One shift-add step of the unsigned multiplier. The upper half of the
// partial product accumulates the multiplicand when the current multiplier
// bit (prod[0]) is set; the 33-bit sum shifts right together with the lower
// half, so the carry out of the add lands in the top bit and is never lost.
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // Conditional add of the multiplicand followed by the right shift.
  always_comb begin
    addend = prod_i[0] ? mcand_i : '0;
    sum    = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    prod_o = {sum, prod_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned multiplier with HI/LO result registers. A MULTU code
// loads the operands and starts a self-timed run of WIDTH shift-add steps;
// the finished product is only committed to HI/LO once the HiLo-open code has
// been seen (either during the run, remembered in pend, or while waiting in
// DONE). MFHI/MFLO read the committed HI/LO through a registered port.
module multu_hilo
  import multu_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             hilo_vld,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dataOut
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 vld_q, vld_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic [2*WIDTH-1:0]   step_prod;

  mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .prod_o  (step_prod)
  );

  // Next-state logic: sequencer, step counter, commit of HI/LO and read port.
  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    mcand_d    = mcand_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    vld_d      = vld_q;

    // Reads see the committed registers, so a same-edge commit returns old data.
    unique case (read_sel(Signal))
      2'b01:   data_out_d = hi_q;
      2'b10:   data_out_d = lo_q;
      default: data_out_d = '0;
    endcase

    unique case (state_q)
      ST_IDLE: begin
        if (Signal == SIG_MULTU) begin
          mcand_d = dataA;
          prod_d  = {{WIDTH{1'b0}}, dataB};
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + CNT_W'(1);
        if (Signal == SIG_HILO_WR) pend_d = 1'b1;
        if (cnt_q == LAST_STEP) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (pend_q || (Signal == SIG_HILO_WR)) begin
          hi_d    = prod_q[2*WIDTH-1:WIDTH];
          lo_d    = prod_q[WIDTH-1:0];
          done_d  = 1'b1;
          vld_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (Signal == SIG_MULTU) begin
          mcand_d = dataA;
          prod_d  = {{WIDTH{1'b0}}, dataB};
          cnt_d   = '0;
          pend_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-run simply abandons it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      prod_q     <= '0;
      mcand_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      vld_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      mcand_q    <= mcand_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      vld_q      <= vld_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = (state_q == ST_RUN);
  assign done     = done_q;
  assign hilo_vld = vld_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign dataOut  = data_out_q;

endmodule

// File: tb/tb_multu_hilo.sv
// Self-checking bench for multu_hilo: a vector table of products plus
// hand-written sequences for commit timing, restart, reset abort and reads.
module tb_multu_hilo;
  import multu_hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Signal;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic        hilo_vld;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] dataOut;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  multu_hilo #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Signal   (Signal),
    .dataA    (dataA),
    .dataB    (dataB),
    .busy     (busy),
    .done     (done),
    .hilo_vld (hilo_vld),
    .hi       (hi),
    .lo       (lo),
    .dataOut  (dataOut)
  );

  always #5 clk = ~clk;

  // Counts done pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  // Guards against a hung run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] x;
    logic [63:0] y;
    x = {32'h0, a};
    y = {32'h0, b};
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
    Signal = code;
    dataA  = a;
    dataB  = b;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic startMult(input logic [31:0] a, input logic [31:0] b, input bit push);
    applyStimulus(SIG_MULTU, a, b);
    if (push) sb_q.push_back(mul64(a, b));
    tick();
  endtask

  task automatic waitDone(input string name, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
    checkOutput({name, " done seen"}, {63'h0, done}, 64'h1);
  endtask

  task automatic scoreCheck(input string name);
    logic [63:0] exp;
    if (sb_q.size() == 0) begin
      checkOutput({name, " scoreboard empty"}, {hi, lo}, 64'hx);
    end else begin
      exp = sb_q.pop_front();
      checkOutput(name, {hi, lo}, exp);
    end
  endtask

  initial begin
    int cycles;
    int d0;
    logic [63:0] prev;
    logic [63:0] nxt;

    vecs[0] = '{32'h0000_0007, 32'h0000_0006, 64'h0};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0000, 32'hDEAD_BEEF, 64'h0};
    vecs[3] = '{32'hCAFE_F00D, 32'h0000_0001, 64'h0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[5] = '{$urandom, $urandom, 64'h0};
    vecs[6] = '{$urandom, $urandom, 64'h0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h8000_0001, 64'h0};
    foreach (vecs[i]) begin
      if (i != 1 && i != 4) vecs[i].exp = mul64(vecs[i].a, vecs[i].b);
    end

    // Reset state
    reset = 1'b1;
    applyStimulus(6'd0, 32'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset busy", {63'h0, busy}, 64'h0);
    checkOutput("reset done", {63'h0, done}, 64'h0);
    checkOutput("reset hilo_vld", {63'h0, hilo_vld}, 64'h0);
    checkOutput("reset hi/lo", {hi, lo}, 64'h0);
    checkOutput("reset dataOut", {32'h0, dataOut}, 64'h0);
    reset = 1'b0;
    tick();

    // 3*5 with HILO_WR arriving only after DONE
    startMult(32'd3, 32'd5, 1'b1);
    checkOutput("3x5 busy after start", {63'h0, busy}, 64'h1);
    applyStimulus(6'd0, 32'hAAAA_AAAA, 32'h5555_5555);
    repeat (31) tick();
    checkOutput("3x5 busy at step 31", {63'h0, busy}, 64'h1);
    tick();
    checkOutput("3x5 busy in DONE", {63'h0, busy}, 64'h0);
    repeat (3) tick();
    checkOutput("3x5 hold no done", {63'h0, done}, 64'h0);
    checkOutput("3x5 hold hilo_vld", {63'h0, hilo_vld}, 64'h0);
    d0 = done_cnt;
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    tick();
    checkOutput("3x5 done pulse", {63'h0, done}, 64'h1);
    checkOutput("3x5 hi/lo const", {hi, lo}, 64'h0000_0000_0000_000F);
    scoreCheck("3x5 scoreboard");
    applyStimulus(6'd0, 32'h0, 32'h0);
    tick();
    checkOutput("3x5 done low after", {63'h0, done}, 64'h0);
    repeat (3) tick();
    checkOutput("3x5 single pulse", 64'(done_cnt - d0), 64'd1);
    checkOutput("3x5 hilo_vld", {63'h0, hilo_vld}, 64'h1);

    // Vector table: HILO_WR during the run, commit at start+33, then reads
    for (int i = 0; i < 8; i++) begin
      applyStimulus(SIG_MULTU, vecs[i].a, vecs[i].b);
      sb_q.push_back(vecs[i].exp);
      tick();
      applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
      waitDone($sformatf("vec%0d", i), cycles);
      checkOutput($sformatf("vec%0d latency", i), 64'(cycles), 64'd33);
      scoreCheck($sformatf("vec%0d product", i));
      applyStimulus(SIG_MFHI, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("vec%0d MFHI", i), {32'h0, dataOut}, {32'h0, vecs[i].exp[63:32]});
      applyStimulus(SIG_MFLO, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("vec%0d MFLO", i), {32'h0, dataOut}, {32'h0, vecs[i].exp[31:0]});
      applyStimulus(6'd0, 32'h0, 32'h0);
      tick();
      checkOutput($sformatf("vec%0d other code", i), {32'h0, dataOut}, 64'h0);
    end

    // Upstream timing: MULTU held 32 cycles, HILO_WR on the final step edge
    applyStimulus(SIG_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    sb_q.push_back(mul64(32'h1234_5678, 32'h9ABC_DEF0));
    tick();
    repeat (31) tick();
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    tick();
    checkOutput("upstream in DONE busy", {63'h0, busy}, 64'h0);
    checkOutput("upstream no early done", {63'h0, done}, 64'h0);
    applyStimulus(6'd0, 32'h0, 32'h0);
    tick();
    checkOutput("upstream commit from pend", {63'h0, done}, 64'h1);
    scoreCheck("upstream product");
    prev = mul64(32'h1234_5678, 32'h9ABC_DEF0);

    // Reads during RUN see old values; same-edge commit+MFHI returns old hi
    nxt = mul64(32'h0BAD_F00D, 32'h7654_3210);
    startMult(32'h0BAD_F00D, 32'h7654_3210, 1'b1);
    applyStimulus(SIG_MFHI, 32'h0, 32'h0);
    tick();
    checkOutput("run MFHI old", {32'h0, dataOut}, {32'h0, prev[63:32]});
    applyStimulus(SIG_MFLO, 32'h0, 32'h0);
    tick();
    checkOutput("run MFLO old", {32'h0, dataOut}, {32'h0, prev[31:0]});
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    tick();
    checkOutput("run hi unchanged", {32'h0, hi}, {32'h0, prev[63:32]});
    applyStimulus(6'd0, 32'h0, 32'h0);
    repeat (29) tick();
    applyStimulus(SIG_MFHI, 32'h0, 32'h0);
    tick();
    checkOutput("commit+MFHI done", {63'h0, done}, 64'h1);
    checkOutput("commit+MFHI old dataOut", {32'h0, dataOut}, {32'h0, prev[63:32]});
    scoreCheck("commit+MFHI product");
    tick();
    checkOutput("MFHI after commit", {32'h0, dataOut}, {32'h0, nxt[63:32]});

    // Reset at step 10 aborts the run
    reset = 1'b1;
    tick();
    reset = 1'b0;
    startMult(32'h0001_0001, 32'h0002_0002, 1'b0);
    applyStimulus(6'd0, 32'h0, 32'h0);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort busy", {63'h0, busy}, 64'h0);
    checkOutput("abort hi/lo", {hi, lo}, 64'h0);
    checkOutput("abort hilo_vld", {63'h0, hilo_vld}, 64'h0);
    d0 = done_cnt;
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    repeat (40) tick();
    checkOutput("abort no commit", 64'(done_cnt - d0), 64'd0);
    checkOutput("abort hilo_vld later", {63'h0, hilo_vld}, 64'h0);
    startMult(32'h0000_FFFF, 32'h0001_0000, 1'b1);
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    waitDone("post-abort", cycles);
    scoreCheck("post-abort product");
    applyStimulus(6'd0, 32'h0, 32'h0);
    tick();

    // MULTU while in DONE discards the first product and restarts
    d0 = done_cnt;
    startMult(32'h1111_1111, 32'h2222_2222, 1'b0);
    applyStimulus(6'd0, 32'h0, 32'h0);
    repeat (32) tick();
    checkOutput("restart reached DONE", {63'h0, busy}, 64'h0);
    startMult(32'h3333_3333, 32'h4444_4444, 1'b1);
    checkOutput("restart busy", {63'h0, busy}, 64'h1);
    applyStimulus(SIG_HILO_WR, 32'h0, 32'h0);
    waitDone("restart", cycles);
    checkOutput("restart latency", 64'(cycles), 64'd33);
    scoreCheck("restart product");
    applyStimulus(6'd0, 32'h0, 32'h0);
    repeat (3) tick();
    checkOutput("restart single commit", 64'(done_cnt - d0), 64'd1);
    checkOutput("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
